id_ex_stage: RTL and testbench

- ID/EX pipeline register with integrated load-use hazard detection.
- Sits between the decode stage and the execute stage.
- Captures decoded operands, register specifiers and control bits each cycle, and supplies IdExRs/IdExRt to the forwarding unit.
- Inserts one bubble and raises Stall when the instruction in decode needs a value still being loaded by the instruction in execute.

---
 rtl/mips_pkg.sv | 10 +
 rtl/hazard_detect.sv | 24 ++
 rtl/id_ex_stage.sv | 150 +++++++++++++++
 tb/tb_id_ex_stage.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared pipeline widths and constants for the MIPS-style datapath.
package mips_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned REG_AW  = 5;
    localparam int unsigned ALUOP_W = 3;

    localparam logic [4:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard detection feeding the ID/EX stall logic.
module hazard_detect #(
    parameter int unsigned REG_AW = mips_pkg::REG_AW
) (
    input  logic              mem_read_i,
    input  logic [REG_AW-1:0] ex_rt_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              hold_i,
    input  logic              flush_i,
    output logic              load_use_o,
    output logic              stall_o
);
    import mips_pkg::*;

    // A load in EX targeting a source of the decode instruction; r0 never hazards.
    assign load_use_o = mem_read_i
                     && (ex_rt_i != REG_AW'(ZERO_REG))
                     && ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));

    // A frozen pipe or a discarded decode instruction needs no stall.
    assign stall_o = load_use_o && !hold_i && !flush_i;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with integrated load-use bubble insertion.
// Optional macro ID_EX_STALL_CNT_EN adds a saturating 16-bit StallCnt output.
module id_ex_stage #(
    parameter int unsigned DATA_W  = mips_pkg::DATA_W,
    parameter int unsigned REG_AW  = mips_pkg::REG_AW,
    parameter int unsigned ALUOP_W = mips_pkg::ALUOP_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               Hold,
    input  logic               Flush,
    input  logic [REG_AW-1:0]  IfIdRs,
    input  logic [REG_AW-1:0]  IfIdRt,
    input  logic [REG_AW-1:0]  IfIdRd,
    input  logic [DATA_W-1:0]  RdDataA,
    input  logic [DATA_W-1:0]  RdDataB,
    input  logic [DATA_W-1:0]  Imm,
    input  logic               CtlRegWrite,
    input  logic               CtlMemRead,
    input  logic               CtlMemWrite,
    input  logic               CtlMemToReg,
    input  logic               CtlRegDst,
    input  logic               CtlAluSrc,
    input  logic [ALUOP_W-1:0] CtlAluOp,
    output logic [REG_AW-1:0]  IdExRs,
    output logic [REG_AW-1:0]  IdExRt,
    output logic [REG_AW-1:0]  IdExRd,
    output logic [DATA_W-1:0]  IdExA,
    output logic [DATA_W-1:0]  IdExB,
    output logic [DATA_W-1:0]  IdExImm,
    output logic               IdExRegWrite,
    output logic               IdExMemRead,
    output logic               IdExMemWrite,
    output logic               IdExMemToReg,
    output logic               IdExRegDst,
    output logic               IdExAluSrc,
    output logic [ALUOP_W-1:0] IdExAluOp,
    output logic               Stall
`ifdef ID_EX_STALL_CNT_EN
    ,
    output logic [15:0]        StallCnt
`endif
);
    import mips_pkg::*;

    localparam int unsigned CTL_W = 6;

    logic [REG_AW-1:0]  rs_q,  rs_d;
    logic [REG_AW-1:0]  rt_q,  rt_d;
    logic [REG_AW-1:0]  rd_q,  rd_d;
    logic [DATA_W-1:0]  a_q,   a_d;
    logic [DATA_W-1:0]  b_q,   b_d;
    logic [DATA_W-1:0]  imm_q, imm_d;
    logic [CTL_W-1:0]   ctl_q, ctl_d;   // {RegWrite, MemRead, MemWrite, MemToReg, RegDst, AluSrc}
    logic [ALUOP_W-1:0] op_q,  op_d;
    logic               load_use;

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_hazard_detect (
        .mem_read_i (ctl_q[4]),
        .ex_rt_i    (rt_q),
        .id_rs_i    (IfIdRs),
        .id_rt_i    (IfIdRt),
        .hold_i     (Hold),
        .flush_i    (Flush),
        .load_use_o (load_use),
        .stall_o    (Stall)
    );

    // Next-state: hold everything, else load fields and bubble the controls on flush/load-use.
    always_comb begin
        rs_d  = rs_q;
        rt_d  = rt_q;
        rd_d  = rd_q;
        a_d   = a_q;
        b_d   = b_q;
        imm_d = imm_q;
        ctl_d = ctl_q;
        op_d  = op_q;
        if (!Hold) begin
            rs_d  = IfIdRs;
            rt_d  = IfIdRt;
            rd_d  = IfIdRd;
            a_d   = RdDataA;
            b_d   = RdDataB;
            imm_d = Imm;
            if (Flush || load_use) begin
                ctl_d = '0;
                op_d  = '0;
            end else begin
                ctl_d = {CtlRegWrite, CtlMemRead, CtlMemWrite, CtlMemToReg, CtlRegDst, CtlAluSrc};
                op_d  = CtlAluOp;
            end
        end
    end

    // Pipeline register; reset state is a NOP bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_q  <= '0;
            rt_q  <= '0;
            rd_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            imm_q <= '0;
            ctl_q <= '0;
            op_q  <= '0;
        end else begin
            rs_q  <= rs_d;
            rt_q  <= rt_d;
            rd_q  <= rd_d;
            a_q   <= a_d;
            b_q   <= b_d;
            imm_q <= imm_d;
            ctl_q <= ctl_d;
            op_q  <= op_d;
        end
    end

    assign IdExRs       = rs_q;
    assign IdExRt       = rt_q;
    assign IdExRd       = rd_q;
    assign IdExA        = a_q;
    assign IdExB        = b_q;
    assign IdExImm      = imm_q;
    assign IdExRegWrite = ctl_q[5];
    assign IdExMemRead  = ctl_q[4];
    assign IdExMemWrite = ctl_q[3];
    assign IdExMemToReg = ctl_q[2];
    assign IdExRegDst   = ctl_q[1];
    assign IdExAluSrc   = ctl_q[0];
    assign IdExAluOp    = op_q;

`ifdef ID_EX_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    // Saturating count of stall cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else if (Stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign StallCnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed table-driven bench for id_ex_stage.
module tb_id_ex_stage;

    localparam int unsigned OUT_W = 120;
    localparam int NVEC = 17;
    localparam int K_LOAD = 0;
    localparam int K_BUBBLE = 1;
    localparam int K_HOLD = 2;

    typedef struct {
        logic        hold;
        logic        flush;
        logic [4:0]  rs, rt, rd;
        logic [31:0] a, b, imm;
        logic [5:0]  ctl;
        logic [2:0]  op;
        logic        exp_stall;
        int          kind;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic hold, flush;
    logic [4:0] rs, rt, rd;
    logic [31:0] a, b, imm;
    logic [5:0] ctl;
    logic [2:0] op;
    logic [4:0] o_rs, o_rt, o_rd;
    logic [31:0] o_a, o_b, o_imm;
    logic o_rw, o_mr, o_mw, o_m2r, o_rdst, o_as;
    logic [2:0] o_op;
    logic stall;
`ifdef ID_EX_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int errors = 0;
    int checks = 0;
    vec_t vecs [NVEC];
    logic [OUT_W-1:0] exp_q;
    logic [OUT_W-1:0] in_pack;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk          (clk),
        .rst          (rst),
        .Hold         (hold),
        .Flush        (flush),
        .IfIdRs       (rs),
        .IfIdRt       (rt),
        .IfIdRd       (rd),
        .RdDataA      (a),
        .RdDataB      (b),
        .Imm          (imm),
        .CtlRegWrite  (ctl[5]),
        .CtlMemRead   (ctl[4]),
        .CtlMemWrite  (ctl[3]),
        .CtlMemToReg  (ctl[2]),
        .CtlRegDst    (ctl[1]),
        .CtlAluSrc    (ctl[0]),
        .CtlAluOp     (op),
        .IdExRs       (o_rs),
        .IdExRt       (o_rt),
        .IdExRd       (o_rd),
        .IdExA        (o_a),
        .IdExB        (o_b),
        .IdExImm      (o_imm),
        .IdExRegWrite (o_rw),
        .IdExMemRead  (o_mr),
        .IdExMemWrite (o_mw),
        .IdExMemToReg (o_m2r),
        .IdExRegDst   (o_rdst),
        .IdExAluSrc   (o_as),
        .IdExAluOp    (o_op),
        .Stall        (stall)
`ifdef ID_EX_STALL_CNT_EN
        ,
        .StallCnt     (stall_cnt)
`endif
    );

    function automatic vec_t mk(input logic h, input logic f,
                                input logic [4:0] vrs, input logic [4:0] vrt, input logic [4:0] vrd,
                                input logic [31:0] va, input logic [31:0] vb, input logic [31:0] vimm,
                                input logic [5:0] vctl, input logic [2:0] vop,
                                input logic st, input int k);
        vec_t v;
        v.hold = h; v.flush = f; v.rs = vrs; v.rt = vrt; v.rd = vrd;
        v.a = va; v.b = vb; v.imm = vimm; v.ctl = vctl; v.op = vop;
        v.exp_stall = st; v.kind = k;
        return v;
    endfunction

    function automatic logic [OUT_W-1:0] actual();
        return {o_rs, o_rt, o_rd, o_a, o_b, o_imm, o_rw, o_mr, o_mw, o_m2r, o_rdst, o_as, o_op};
    endfunction

    task automatic drive(input vec_t v);
        hold = v.hold; flush = v.flush; rs = v.rs; rt = v.rt; rd = v.rd;
        a = v.a; b = v.b; imm = v.imm; ctl = v.ctl; op = v.op;
    endtask

    task automatic check_out(input string name, input logic [OUT_W-1:0] exp);
        checks++;
        if (actual() !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, actual(), exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    initial begin
        // ctl = {RegWrite, MemRead, MemWrite, MemToReg, RegDst, AluSrc}
        vecs[0]  = mk(0, 0, 5'd3, 5'd4, 5'd5, 32'h11,  32'h22,  32'h33, 6'b100000, 3'd2, 0, K_LOAD);
        vecs[1]  = mk(0, 0, 5'd1, 5'd2, 5'd0, 32'h100, 32'h200, 32'h4,  6'b110101, 3'd0, 0, K_LOAD);
        vecs[2]  = mk(0, 0, 5'd2, 5'd6, 5'd7, 32'haa,  32'hbb,  32'hcc, 6'b100010, 3'd2, 1, K_BUBBLE);
        vecs[3]  = mk(0, 0, 5'd2, 5'd6, 5'd7, 32'haa,  32'hbb,  32'hcc, 6'b100010, 3'd2, 0, K_LOAD);
        vecs[4]  = mk(0, 0, 5'd0, 5'd0, 5'd9, 32'd1,   32'd2,   32'd3,  6'b010000, 3'd0, 0, K_LOAD);
        vecs[5]  = mk(0, 0, 5'd0, 5'd0, 5'd8, 32'd4,   32'd5,   32'd6,  6'b100000, 3'd1, 0, K_LOAD);
        vecs[6]  = mk(0, 0, 5'd1, 5'd7, 5'd2, 32'd7,   32'd8,   32'd9,  6'b100000, 3'd3, 0, K_LOAD);
        vecs[7]  = mk(0, 0, 5'd9, 5'd7, 5'd3, 32'd10,  32'd11,  32'd12, 6'b000001, 3'd4, 0, K_LOAD);
        vecs[8]  = mk(0, 1, 5'd1, 5'd2, 5'd3, 32'd13,  32'd14,  32'd15, 6'b100000, 3'd5, 0, K_BUBBLE);
        vecs[9]  = mk(0, 0, 5'd4, 5'd5, 5'd6, 32'd16,  32'd17,  32'd18, 6'b010000, 3'd6, 0, K_LOAD);
        vecs[10] = mk(1, 1, 5'd0, 5'd5, 5'd1, 32'd19,  32'd20,  32'd21, 6'b100000, 3'd7, 0, K_HOLD);
        vecs[11] = mk(1, 0, 5'd5, 5'd0, 5'd1, 32'd22,  32'd23,  32'd24, 6'b100000, 3'd7, 0, K_HOLD);
        vecs[12] = mk(0, 1, 5'd5, 5'd0, 5'd1, 32'd25,  32'd26,  32'd27, 6'b100000, 3'd7, 0, K_BUBBLE);
        vecs[13] = mk(0, 0, 5'd0, 5'd2, 5'd0, 32'd28,  32'd29,  32'd30, 6'b110101, 3'd0, 0, K_LOAD);
        vecs[14] = mk(0, 0, 5'd2, 5'd3, 5'd0, 32'd31,  32'd32,  32'd33, 6'b110101, 3'd0, 1, K_BUBBLE);
        vecs[15] = mk(0, 0, 5'd2, 5'd3, 5'd0, 32'd31,  32'd32,  32'd33, 6'b110101, 3'd0, 0, K_LOAD);
        vecs[16] = mk(0, 0, 5'd3, 5'd9, 5'd4, 32'd34,  32'd35,  32'd36, 6'b100000, 3'd1, 1, K_BUBBLE);

        rst = 1'b1;
        drive(mk(0, 0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 6'd0, 3'd0, 0, K_LOAD));
        exp_q = '0;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset_outputs", '0);
        check_bit("reset_stall", stall, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            in_pack = {vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].a, vecs[i].b, vecs[i].imm,
                       vecs[i].ctl, vecs[i].op};
            #1;
            check_bit($sformatf("vec%0d_stall", i), stall, vecs[i].exp_stall);
            if (vecs[i].kind == K_LOAD)        exp_q = in_pack;
            else if (vecs[i].kind == K_BUBBLE) exp_q = {in_pack[OUT_W-1:9], 9'd0};
            @(posedge clk);
            #1;
            check_out($sformatf("vec%0d_out", i), exp_q);
        end

`ifdef ID_EX_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 16'd3) begin
            errors++;
            $display("FAIL stall_cnt_three: got %0d expected 3", stall_cnt);
        end
`endif

        // Asynchronous reset between edges with a full register.
        @(negedge clk);
        drive(vecs[0]);
        @(posedge clk);
        #1;
        check_out("full_before_reset", {vecs[0].rs, vecs[0].rt, vecs[0].rd, vecs[0].a, vecs[0].b,
                                        vecs[0].imm, vecs[0].ctl, vecs[0].op});
        #2;
        rst = 1'b1;
        #1;
        check_out("async_reset_outputs", '0);
        check_bit("async_reset_stall", stall, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Reset asserted while a load-use stall is pending.
        drive(vecs[1]);
        @(posedge clk);
        @(negedge clk);
        drive(vecs[2]);
        #1;
        check_bit("midstall_stall_before", stall, 1'b1);
        rst = 1'b1;
        #1;
        check_bit("midstall_stall_after_rst", stall, 1'b0);
        check_out("midstall_outputs_after_rst", '0);
        @(negedge clk);
        rst = 1'b0;

`ifdef ID_EX_STALL_CNT_EN
        force dut.stall_cnt_q = 16'hFFFF;
        #1;
        release dut.stall_cnt_q;
        drive(vecs[1]);
        @(posedge clk);
        @(negedge clk);
        drive(vecs[2]);
        @(posedge clk);
        #1;
        checks++;
        if (stall_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL stall_cnt_saturate: got %h expected ffff", stall_cnt);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
